// File: rtl/nx_stream_buffer_pkg.sv
// nx_stream_buffer_pkg: shared helpers for the stream buffer.
//
// Contents:
//   next_index() - circular index advance used by the buffer's read and write pointers.
//
// Optional feature macro used by the buffer: NX_STREAM_BUFFER_STATS_EN.
package nx_stream_buffer_pkg;

    // Advance a circular index, wrapping from depth-1 back to 0.
    function automatic int unsigned next_index(input int unsigned idx,
                                               input int unsigned depth);
        return (idx == depth - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/nx_stream_buffer.sv
// nx_stream_buffer: valid/ready FIFO with registered inbound ready.
//
// Parameters:
//   WIDTH - payload width in bits (>= 1)
//   DEPTH - number of storage entries (>= 2, any value)
//
// Ports:
//   i_clk            - clock, all state updates on the rising edge
//   i_rst            - synchronous active-high reset (clears state and storage)
//   i_flush          - synchronous discard of all buffered entries
//   i_inbound_data   - inbound payload
//   i_inbound_valid  - inbound payload present
//   o_inbound_ready  - buffer can accept a payload (registered, = !full)
//   o_outbound_data  - head-of-queue payload
//   o_outbound_valid - head-of-queue payload present
//   i_outbound_ready - downstream accepts the payload
//   o_level          - current occupancy            (NX_STREAM_BUFFER_STATS_EN only)
//   o_high_water     - peak occupancy since reset   (NX_STREAM_BUFFER_STATS_EN only)
//
// Optional feature: define NX_STREAM_BUFFER_STATS_EN to add o_level / o_high_water.
module nx_stream_buffer
    import nx_stream_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_inbound_data,
    input  logic                       i_inbound_valid,
    output logic                       o_inbound_ready,
    output logic [WIDTH-1:0]           o_outbound_data,
    output logic                       o_outbound_valid,
    input  logic                       i_outbound_ready
`ifdef NX_STREAM_BUFFER_STATS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic [$clog2(DEPTH+1)-1:0] o_high_water
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic             push, pop;

    assign push = i_inbound_valid && ready_q;
    assign pop  = (count_q != '0) && i_outbound_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            // Flush wins over any push or pop in the same cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = PTR_W'(next_index(32'(wr_ptr_q), DEPTH));
            if (pop)  rd_ptr_d = PTR_W'(next_index(32'(rd_ptr_q), DEPTH));
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        // Ready is registered from the next count, so a pop while full only
        // reopens the inbound side one cycle later.
        ready_d = (count_d != FULL_COUNT);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            if (push && !i_flush) begin
                mem_q[wr_ptr_q] <= i_inbound_data;
            end
        end
    end

    assign o_inbound_ready  = ready_q;
    assign o_outbound_valid = (count_q != '0);
    assign o_outbound_data  = mem_q[rd_ptr_q];

`ifdef NX_STREAM_BUFFER_STATS_EN
    logic [CNT_W-1:0] high_water_q, high_water_d;

    // Tracks the peak of the next count; flush lowers the count but not the peak.
    always_comb begin
        high_water_d = high_water_q;
        if (count_d > high_water_q) high_water_d = count_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            high_water_q <= '0;
        end else begin
            high_water_q <= high_water_d;
        end
    end

    assign o_level      = count_q;
    assign o_high_water = high_water_q;
`endif

endmodule

// File: tb/tb_nx_stream_buffer.sv
// tb_nx_stream_buffer: randomized and directed bench for nx_stream_buffer.
// Unit 0 is WIDTH=8/DEPTH=4, unit 1 is WIDTH=8/DEPTH=3. Both are checked every
// cycle against a queue model; stats ports are checked when
// NX_STREAM_BUFFER_STATS_EN is defined.
module tb_nx_stream_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [2];
    logic       flush [2];
    logic       vin   [2];
    logic       rin   [2];
    logic       rdy_o [2];
    logic       val_o [2];
    logic [7:0] din   [2];
    logic [7:0] dout  [2];

`ifdef NX_STREAM_BUFFER_STATS_EN
    logic [2:0] lvl4, hw4;
    logic [1:0] lvl3, hw3;
`endif

    nx_stream_buffer #(.WIDTH(8), .DEPTH(4)) u_dut4 (
        .i_clk            (clk),
        .i_rst            (rst[0]),
        .i_flush          (flush[0]),
        .i_inbound_data   (din[0]),
        .i_inbound_valid  (vin[0]),
        .o_inbound_ready  (rdy_o[0]),
        .o_outbound_data  (dout[0]),
        .o_outbound_valid (val_o[0]),
        .i_outbound_ready (rin[0])
`ifdef NX_STREAM_BUFFER_STATS_EN
        ,
        .o_level          (lvl4),
        .o_high_water     (hw4)
`endif
    );

    nx_stream_buffer #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .i_clk            (clk),
        .i_rst            (rst[1]),
        .i_flush          (flush[1]),
        .i_inbound_data   (din[1]),
        .i_inbound_valid  (vin[1]),
        .o_inbound_ready  (rdy_o[1]),
        .o_outbound_data  (dout[1]),
        .o_outbound_valid (val_o[1]),
        .i_outbound_ready (rin[1])
`ifdef NX_STREAM_BUFFER_STATS_EN
        ,
        .o_level          (lvl3),
        .o_high_water     (hw3)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq [2][$];     // model contents, head at index 0
    int         hw_m [2];      // model peak occupancy
    logic [7:0] seen [$];      // DUT outputs observed at each pop
    bit         did_push, did_pop;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int depth_of(input int u);
        return (u == 0) ? 4 : 3;
    endfunction

    task automatic check_outputs(input int u);
        check_eq($sformatf("u%0d valid", u), 32'(val_o[u]), 32'(mq[u].size() != 0));
        check_eq($sformatf("u%0d ready", u), 32'(rdy_o[u]), 32'(mq[u].size() < depth_of(u)));
        if (mq[u].size() != 0) begin
            check_eq($sformatf("u%0d data", u), 32'(dout[u]), 32'(mq[u][0]));
        end
`ifdef NX_STREAM_BUFFER_STATS_EN
        check_eq($sformatf("u%0d level", u), (u == 0) ? 32'(lvl4) : 32'(lvl3),
                 32'(mq[u].size()));
        check_eq($sformatf("u%0d high water", u), (u == 0) ? 32'(hw4) : 32'(hw3),
                 32'(hw_m[u]));
`endif
    endtask

    // One clock cycle on unit u; entered and left at a falling edge.
    task automatic cycle(input int u, input logic v, input logic [7:0] d, input logic r);
        check_outputs(u);
        vin[u] = v;
        din[u] = d;
        rin[u] = r;
        did_push = v && (mq[u].size() < depth_of(u));
        did_pop  = r && (mq[u].size() != 0);
        if (did_pop) seen.push_back(dout[u]);
        @(posedge clk);
        if (did_pop)  void'(mq[u].pop_front());
        if (did_push) mq[u].push_back(d);
        if (mq[u].size() > hw_m[u]) hw_m[u] = mq[u].size();
        @(negedge clk);
    endtask

    task automatic do_reset(input int u, input logic v, input logic [7:0] d);
        rst[u] = 1'b1;
        vin[u] = v;
        din[u] = d;
        rin[u] = 1'b1;
        @(posedge clk);
        mq[u].delete();
        hw_m[u] = 0;
        @(negedge clk);
        rst[u] = 1'b0;
        vin[u] = 1'b0;
    endtask

    task automatic do_flush(input int u, input logic v, input logic [7:0] d);
        flush[u] = 1'b1;
        vin[u] = v;
        din[u] = d;
        rin[u] = 1'b1;
        @(posedge clk);
        mq[u].delete();
        @(negedge clk);
        flush[u] = 1'b0;
        vin[u] = 1'b0;
    endtask

    initial begin
        int n, acc, cyc;
        logic hv, hold, r;
        logic [7:0] hd;

        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; flush[u] = 1'b0; vin[u] = 1'b0; rin[u] = 1'b0; din[u] = '0;
            hw_m[u] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int u = 0; u < 2; u++) begin
            check_eq($sformatf("u%0d reset valid", u), 32'(val_o[u]), 32'd0);
            check_eq($sformatf("u%0d reset ready", u), 32'(rdy_o[u]), 32'd1);
            check_eq($sformatf("u%0d reset data", u), 32'(dout[u]), 32'd0);
        end

        // Single push into empty buffer appears one cycle later.
        cycle(0, 1'b1, 8'h11, 1'b0);
        check_eq("u0 first valid", 32'(val_o[0]), 32'd1);
        check_eq("u0 first data", 32'(dout[0]), 32'h11);
        cycle(0, 1'b0, 8'h00, 1'b1);

        // Stalled downstream: four fit, the fifth is held off until a pop.
        seen.delete();
        for (int i = 1; i <= 4; i++) cycle(0, 1'b1, 8'(i), 1'b0);
        check_eq("u0 ready low when full", 32'(rdy_o[0]), 32'd0);
        cycle(0, 1'b1, 8'h05, 1'b0);
        check_eq("u0 fifth held off", 32'(rdy_o[0]), 32'd0);
        check_eq("u0 stalled head stable", 32'(dout[0]), 32'h01);
        cycle(0, 1'b1, 8'h05, 1'b1);
        check_eq("u0 ready after pop", 32'(rdy_o[0]), 32'd1);
        cycle(0, 1'b1, 8'h05, 1'b1);
        repeat (4) cycle(0, 1'b0, 8'h00, 1'b1);
        check_eq("u0 drained", 32'(val_o[0]), 32'd0);
        check_eq("u0 out count", 32'(seen.size()), 32'd5);
        for (int i = 0; i < seen.size(); i++) begin
            check_eq($sformatf("u0 out seq %0d", i), 32'(seen[i]), 32'(i + 1));
        end

        // Streaming: one transfer per cycle, pointers wrap several times.
        seen.delete();
        n = 0;
        for (int k = 0; k < 21; k++) begin
            if (val_o[0]) n++;
            cycle(0, 1'b1, 8'(8'h40 + k), 1'b1);
        end
        check_eq("u0 stream transfers", 32'(n), 32'd20);
        for (int i = 0; i < seen.size(); i++) begin
            check_eq($sformatf("u0 stream seq %0d", i), 32'(seen[i]), 32'(8'h40 + i));
        end
        cycle(0, 1'b0, 8'h00, 1'b1);

        // Reset while full discards contents and the high-water mark.
        for (int i = 0; i < 4; i++) cycle(0, 1'b1, 8'(8'hA0 + i), 1'b0);
        check_eq("u0 full before reset", 32'(rdy_o[0]), 32'd0);
        do_reset(0, 1'b1, 8'hEE);
        check_eq("u0 post-reset valid", 32'(val_o[0]), 32'd0);
        check_eq("u0 post-reset ready", 32'(rdy_o[0]), 32'd1);
        check_eq("u0 post-reset data", 32'(dout[0]), 32'd0);
`ifdef NX_STREAM_BUFFER_STATS_EN
        check_eq("u0 post-reset high water", 32'(hw4), 32'd0);
`endif
        cycle(0, 1'b0, 8'h00, 1'b0);

        // Randomised traffic on DEPTH=3, upstream holds rejected payloads.
        acc = 0; cyc = 0; hold = 1'b0; hv = 1'b0; hd = '0;
        while (acc < 1000 && cyc < 20000) begin
            if (!hold) begin
                hv = ($urandom_range(0, 3) != 0);
                hd = 8'($urandom);
            end
            r = ($urandom_range(0, 99) < (((cyc / 200) % 2 == 0) ? 80 : 30));
            cycle(1, hv, hd, r);
            if (hv && did_push) acc++;
            hold = hv && !did_push;
            cyc++;
        end
        check_eq("u1 payloads accepted", 32'(acc), 32'd1000);
        repeat (4) cycle(1, 1'b0, 8'h00, 1'b1);
        check_eq("u1 drained", 32'(val_o[1]), 32'd0);

        // Flush with a simultaneous push: everything discarded, peak kept.
        do_reset(1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1, 1'b1, 8'(8'h30 + i), 1'b0);
        do_flush(1, 1'b1, 8'h99);
        check_eq("u1 post-flush valid", 32'(val_o[1]), 32'd0);
        check_eq("u1 post-flush ready", 32'(rdy_o[1]), 32'd1);
`ifdef NX_STREAM_BUFFER_STATS_EN
        check_eq("u1 post-flush level", 32'(lvl3), 32'd0);
        check_eq("u1 post-flush high water", 32'(hw3), 32'd3);
`endif
        cycle(1, 1'b1, 8'h5A, 1'b0);
        check_eq("u1 push after flush", 32'(dout[1]), 32'h5A);
        cycle(1, 1'b0, 8'h00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
